// File: rtl/spi_slave_brightness.sv
// SPI Mode 0 slave holding a single brightness register.
// The SPI pins are oversampled on sysclk; frames are {cmd, addr, payload}, MSB first.
// A WRITE to REG_ADDR updates o_brightness. A READ from REG_ADDR returns it on miso
// during the payload phase.
module spi_slave_brightness #(
    parameter int                    CMD_BITS         = 8,
    parameter int                    ADDR_BITS        = 8,
    parameter int                    PAYLOAD_BITS     = 8,
    parameter int                    BRIGHTNESS_WIDTH = 7,
    parameter logic [ADDR_BITS-1:0]  REG_ADDR         = 8'h00,
    parameter logic [CMD_BITS-1:0]   CMD_WRITE        = 8'h01,
    parameter logic [CMD_BITS-1:0]   CMD_READ         = 8'h02
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        sclk,
    input  logic                        cs,
    input  logic                        mosi,
    output logic                        miso,
    output logic [BRIGHTNESS_WIDTH-1:0] o_brightness,
    output logic                        o_bright_valid,
    output logic                        o_rx_dv,
    output logic [CMD_BITS-1:0]         o_cmd,
    output logic [ADDR_BITS-1:0]        o_addr,
    output logic [PAYLOAD_BITS-1:0]     o_payload,
    output logic                        o_frame_err,
    output logic                        o_busy
);

    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(CMD_BITS + ADDR_BITS);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_WAIT_CS
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // Bit 0 is the first synchronizer stage, bit 1 the second, bit 2 the history flop.
    logic [2:0]              r_sclk_sync;
    logic [2:0]              r_cs_sync;
    // mosi needs no history flop: only its level is used, never its edges.
    logic [1:0]              r_mosi_sync;

    logic [CNT_W-1:0]        r_bit_cnt;
    logic [FRAME_BITS-2:0]   r_rx_shift;
    logic [PAYLOAD_BITS-1:0] r_tx_shift;

    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_cs_rise;
    logic                    w_cs_fall;
    logic                    w_mosi;
    logic                    w_in_frame;
    logic                    w_shift_rx;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [FRAME_BITS-1:0]   w_rx_next;
    logic                    w_hdr_done;
    logic                    w_frame_done;
    logic                    w_frame_err;
    logic                    w_load_tx;
    logic                    w_shift_tx;
    logic [CMD_BITS-1:0]     w_hdr_cmd;
    logic [ADDR_BITS-1:0]    w_hdr_addr;
    logic [CMD_BITS-1:0]     w_frm_cmd;
    logic [ADDR_BITS-1:0]    w_frm_addr;
    logic [PAYLOAD_BITS-1:0] w_frm_payload;

    // Bring the asynchronous SPI pins into the sysclk domain.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state always uses non-blocking (<=) so that every flop
        // samples the values from before the clock edge, independent of statement order.
        if (!rst_n) begin
            // Sync flops clear to 0. If cs is already low when reset is released,
            // this produces no falling edge, so no frame starts mid-transfer.
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_cs_sync   <= {r_cs_sync[1:0], cs};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    // Stage 2 of mosi was sampled at the same instant as stage 2 of sclk.
    assign w_mosi      = r_mosi_sync[1];

    assign w_in_frame  = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_shift_rx  = w_in_frame && w_sclk_rise;
    assign w_cnt_next  = r_bit_cnt + CNT_W'(1);
    assign w_rx_next   = {r_rx_shift, w_mosi};

    // Header fields as they stand at the moment the last address bit arrives.
    assign w_hdr_cmd   = w_rx_next[CMD_BITS+ADDR_BITS-1 -: CMD_BITS];
    assign w_hdr_addr  = w_rx_next[ADDR_BITS-1:0];

    // Frame fields as they stand at the moment the last payload bit arrives.
    assign w_frm_cmd     = w_rx_next[FRAME_BITS-1 -: CMD_BITS];
    assign w_frm_addr    = w_rx_next[PAYLOAD_BITS+ADDR_BITS-1 -: ADDR_BITS];
    assign w_frm_payload = w_rx_next[PAYLOAD_BITS-1:0];

    assign w_hdr_done   = (r_state == S_ADDR) && w_sclk_rise && (w_cnt_next == CNT_HDR);
    // A final rising edge that coincides with the cs rise is counted first,
    // so the frame still completes.
    assign w_frame_done = (r_state == S_DATA) && w_sclk_rise && (w_cnt_next == CNT_FRAME);
    assign w_frame_err  = w_in_frame && w_cs_rise && !w_frame_done;
    assign w_load_tx    = w_hdr_done && !w_cs_rise &&
                          (w_hdr_cmd == CMD_READ) && (w_hdr_addr == REG_ADDR);
    // The payload MSB is presented when DATA is entered. The falling edge that
    // immediately follows must not shift it away before the master samples it.
    assign w_shift_tx   = (r_state == S_DATA) && w_sclk_fall && (r_bit_cnt != CNT_HDR);

    // Register the FSM state.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A cs rise aborts any phase; bit counts advance the phases.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_next = S_CMD;
            end
            S_CMD: begin
                if (w_cs_rise)                                      w_state_next = S_IDLE;
                else if (w_sclk_rise && (w_cnt_next == CNT_CMD))    w_state_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_cs_rise)                                      w_state_next = S_IDLE;
                else if (w_hdr_done)                                w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_frame_done)                                   w_state_next = w_cs_rise ? S_IDLE : S_WAIT_CS;
                else if (w_cs_rise)                                 w_state_next = S_IDLE;
            end
            S_WAIT_CS: begin
                if (w_cs_rise)                                      w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: receive shifter, transmit shifter, frame outputs and brightness register.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            o_brightness   <= '0;
            o_bright_valid <= 1'b0;
            o_rx_dv        <= 1'b0;
            o_cmd          <= '0;
            o_addr         <= '0;
            o_payload      <= '0;
            o_frame_err    <= 1'b0;
        end else begin
            o_rx_dv        <= 1'b0;
            o_bright_valid <= 1'b0;
            o_frame_err    <= 1'b0;

            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_rx) begin
                r_bit_cnt  <= w_cnt_next;
                r_rx_shift <= w_rx_next[FRAME_BITS-2:0];
            end

            if (r_state == S_IDLE || w_frame_done || w_frame_err) begin
                r_tx_shift <= '0;
            end else if (w_load_tx) begin
                r_tx_shift <= PAYLOAD_BITS'(o_brightness);
            end else if (w_shift_tx) begin
                r_tx_shift <= {r_tx_shift[PAYLOAD_BITS-2:0], 1'b0};
            end

            if (w_frame_done) begin
                o_rx_dv   <= 1'b1;
                o_cmd     <= w_frm_cmd;
                o_addr    <= w_frm_addr;
                o_payload <= w_frm_payload;
                if ((w_frm_cmd == CMD_WRITE) && (w_frm_addr == REG_ADDR)) begin
                    o_brightness   <= w_frm_payload[BRIGHTNESS_WIDTH-1:0];
                    o_bright_valid <= 1'b1;
                end
            end

            if (w_frame_err) begin
                o_frame_err <= 1'b1;
            end
        end
    end

    // The transmit shifter is zero except during the payload of a register read.
    assign miso   = r_tx_shift[PAYLOAD_BITS-1];
    assign o_busy = (r_state != S_IDLE);

endmodule
